memory_access: RTL and testbench
================================

Name: memory_access

Overview:
Pipeline stage directly downstream of the execution stage. Consumes the execution stage's registered result bundle and performs the data-memory load/store or UART receive. Produces a single-cycle writeback bundle for the register-file/writeback stage and forwards branch information to the fetch stage. Contains the core's data memory: word-addressed, synchronous-read.

Parameters:
DATA_MEM_WIDTH, 10, log2 of data memory depth in 32-bit words
INST_MEM_WIDTH, 5, width of instruction-memory PCs passed through

Ports:
CLK  in  1  clock
reset  in  1  synchronous, active-high reset
distinct  in  1  upstream bundle is a real instruction (not bubble)
valid  in  1  upstream bundle valid this cycle (single-cycle pulse)
AorF  in  1  destination register file: 0 integer, 1 float
RegWrite  in  1  instruction writes a register
MemtoReg  in  2  writeback source select
Branch  in  2  branch kind, passed through
MemWrite  in  1  store
MemRead  in  1  load
UARTtoReg  in  1  read one byte from UART RX
result  in  32  ALU/FPU result; also the memory byte address
register_data  in  32  store data
rdist  in  5  destination register
pc1  in  INST_MEM_WIDTH  pc+1 (link value)
pc2  in  INST_MEM_WIDTH  branch target
uart_rx_data  in  8  UART RX byte
uart_rx_valid  in  1  RX byte available
uart_rx_ready  out  1  one-cycle pulse: byte consumed
busy  out  1  stage cannot accept; hazard unit stalls upstream
wb_valid  out  1  one-cycle pulse: writeback bundle valid
wb_RegWrite  out  1  registered RegWrite
wb_AorF  out  1  registered AorF
wb_rdist  out  5  registered destination
wb_data  out  32  writeback value
br_Branch  out  2  registered Branch
br_target  out  INST_MEM_WIDTH  registered pc2

Behaviour:
- Accept condition: valid && distinct && state==IDLE. Bundles with distinct=0 are ignored. Bundles arriving while busy=1 are dropped; upstream must honour busy.
- States:
  - IDLE
  - LOAD_WAIT: memory read in flight
  - UART_WAIT: waiting for an RX byte
- Transitions and latency from the accept cycle:
  - Plain ALU, store, or link op: IDLE -> IDLE. wb_valid asserts next cycle (latency 1).
  - MemRead: IDLE -> LOAD_WAIT -> IDLE. wb_valid asserts 2 cycles after accept.
  - UARTtoReg: IDLE -> UART_WAIT. Stays there until uart_rx_valid=1. In that cycle: capture uart_rx_data, pulse uart_rx_ready, return to IDLE. wb_valid asserts the next cycle.
  - If uart_rx_valid is already 1 in the cycle after accept, latency is 2.
- busy = (state != IDLE), combinational.
- Address: word index = result[DATA_MEM_WIDTH+1:2]. Low 2 bits are ignored. Upper bits wrap (no fault).
- Store: memory written on the accept clock edge with register_data. Store and load are never both set; if both are set, MemWrite wins and no read is performed.
- Memory read: registered address, data valid in LOAD_WAIT.
- wb_data select:
  - UARTtoReg=1: {24'b0, byte}, regardless of MemtoReg.
  - Otherwise MemtoReg 00: result.
  - MemtoReg 01: memory word.
  - MemtoReg 10: pc1 zero-extended to 32 bits.
  - MemtoReg 11: result.
- Registered outputs (wb_RegWrite, wb_AorF, wb_rdist, br_Branch, br_target) are captured at accept and update with wb_valid. They hold between pulses.
- Stores emit wb_valid with wb_RegWrite as supplied (normally 0).
- wb_valid and uart_rx_ready are strictly single-cycle pulses.
- Reset values:
  - state IDLE; busy 0; wb_valid 0; uart_rx_ready 0.
  - wb_RegWrite 0; wb_AorF 0; wb_rdist 0; wb_data 0.
  - br_Branch 2'b11 (no branch); br_target 0.
  - Memory contents are not cleared.
- Reset mid-operation: any pending load or UART wait is abandoned with no wb_valid. No uart_rx_ready is issued after reset asserts. A store accepted in the same cycle as reset is not written.
- Simultaneous accept and a stale uart_rx_valid in IDLE: the byte is not consumed until UART_WAIT.

Test Plan:
- Reset, then idle 5 cycles -> wb_valid=0, br_Branch=2'b11, busy=0, uart_rx_ready never pulses.
- ALU op (result=0x1234, MemtoReg=00, RegWrite=1, rdist=7) -> next cycle wb_valid=1, wb_data=0x1234, wb_rdist=7; low afterwards.
- Store register_data=0xDEADBEEF at result=0x40, then load at result=0x43 with MemtoReg=01 -> load wb_valid 2 cycles after accept, wb_data=0xDEADBEEF, busy=1 during LOAD_WAIT.
- UARTtoReg with uart_rx_valid held 0 for 4 cycles, then 1 with byte 0xA5 -> single uart_rx_ready pulse in that cycle; next cycle wb_data=0x000000A5; busy=1 throughout the wait.
- Link op (MemtoReg=10, pc1=5, Branch=2'b01, pc2=9) -> wb_data=5, br_Branch=01, br_target=9.
- Reset asserted during UART_WAIT, then uart_rx_valid=1 -> no uart_rx_ready, no wb_valid, state IDLE. Bundle with distinct=0 and valid=1 -> ignored.

Source files
------------

// File: rtl/memory_access.sv
// Memory-access pipeline stage: data-memory load/store or UART byte receive,
// then a one-cycle writeback pulse plus pass-through of branch information.
module memory_access #(
    parameter int DATA_MEM_WIDTH = 10,
    parameter int INST_MEM_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      distinct,
    input  logic                      valid,
    input  logic                      AorF,
    input  logic                      RegWrite,
    input  logic [1:0]                MemtoReg,
    input  logic [1:0]                Branch,
    input  logic                      MemWrite,
    input  logic                      MemRead,
    input  logic                      UARTtoReg,
    input  logic [31:0]               result,
    input  logic [31:0]               register_data,
    input  logic [4:0]                rdist,
    input  logic [INST_MEM_WIDTH-1:0] pc1,
    input  logic [INST_MEM_WIDTH-1:0] pc2,
    input  logic [7:0]                uart_rx_data,
    input  logic                      uart_rx_valid,
    output logic                      uart_rx_ready,
    output logic                      busy,
    output logic                      wb_valid,
    output logic                      wb_RegWrite,
    output logic                      wb_AorF,
    output logic [4:0]                wb_rdist,
    output logic [31:0]               wb_data,
    output logic [1:0]                br_Branch,
    output logic [INST_MEM_WIDTH-1:0] br_target
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, UART_WAIT} state_t;

    // Fields of an accepted bundle that are still needed when the stage completes.
    typedef struct packed {
        logic                      regwrite;
        logic                      aorf;
        logic [4:0]                rdist;
        logic [1:0]                memtoreg;
        logic [1:0]                branch;
        logic [INST_MEM_WIDTH-1:0] pc1;
        logic [INST_MEM_WIDTH-1:0] pc2;
        logic [31:0]               result;
    } pend_t;

    typedef struct packed {
        logic                      regwrite;
        logic                      aorf;
        logic [4:0]                rdist;
        logic [31:0]               data;
        logic [1:0]                branch;
        logic [INST_MEM_WIDTH-1:0] target;
    } out_t;

    localparam out_t OUT_RESET = '{regwrite: 1'b0, aorf: 1'b0, rdist: 5'd0, data: 32'd0,
                                   branch: 2'b11, target: '0};

    state_t state_q, state_d;
    pend_t  pend_q, pend_d;
    out_t   out_q, out_d;
    logic   wb_valid_q, wb_valid_d;

    logic [31:0]               mem [2**DATA_MEM_WIDTH];
    logic [31:0]               mem_rdata_q;
    logic [DATA_MEM_WIDTH-1:0] addr;
    logic                      accept;
    pend_t                     in_bundle;

    function automatic logic [31:0] wb_select(input logic [1:0] sel, input logic [31:0] res,
                                              input logic [31:0] word,
                                              input logic [INST_MEM_WIDTH-1:0] pc);
        case (sel)
            2'b01:   return word;
            2'b10:   return {{(32-INST_MEM_WIDTH){1'b0}}, pc};
            default: return res;
        endcase
    endfunction

    function automatic out_t complete(input pend_t p, input logic [31:0] data);
        return '{regwrite: p.regwrite, aorf: p.aorf, rdist: p.rdist, data: data,
                 branch: p.branch, target: p.pc2};
    endfunction

    assign addr      = result[DATA_MEM_WIDTH+1:2];
    assign accept    = valid && distinct && (state_q == IDLE);
    assign in_bundle = '{regwrite: RegWrite, aorf: AorF, rdist: rdist, memtoreg: MemtoReg,
                         branch: Branch, pc1: pc1, pc2: pc2, result: result};

    assign busy          = (state_q != IDLE);
    // Gated by reset so an abandoned UART wait never consumes a byte.
    assign uart_rx_ready = (state_q == UART_WAIT) && uart_rx_valid && !reset;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        out_d      = out_q;
        wb_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pend_d = in_bundle;
                    if (UARTtoReg) begin
                        state_d = UART_WAIT;
                    end else if (MemRead && !MemWrite) begin
                        state_d = LOAD_WAIT;
                    end else begin
                        wb_valid_d = 1'b1;
                        out_d      = complete(in_bundle, wb_select(MemtoReg, result, 32'd0, pc1));
                    end
                end
            end
            LOAD_WAIT: begin
                state_d    = IDLE;
                wb_valid_d = 1'b1;
                out_d      = complete(pend_q, wb_select(pend_q.memtoreg, pend_q.result,
                                                        mem_rdata_q, pend_q.pc1));
            end
            UART_WAIT: begin
                if (uart_rx_valid) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    out_d      = complete(pend_q, {24'd0, uart_rx_data});
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            out_q      <= OUT_RESET;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            out_q      <= out_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    // NOTE: the memory array has no reset branch; clearing it would turn the RAM into flops.
    always_ff @(posedge CLK) begin
        if (accept && MemWrite && !reset) begin
            mem[addr] <= register_data;
        end
        if (accept && !MemWrite) begin
            mem_rdata_q <= mem[addr];
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_RegWrite = out_q.regwrite;
    assign wb_AorF     = out_q.aorf;
    assign wb_rdist    = out_q.rdist;
    assign wb_data     = out_q.data;
    assign br_Branch   = out_q.branch;
    assign br_target   = out_q.target;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access: inputs driven and outputs
// sampled on the falling edge, expected values hand-computed per scenario.
module tb_memory_access;

    logic        CLK = 1'b0;
    logic        reset;
    logic        distinct, valid, AorF, RegWrite, MemWrite, MemRead, UARTtoReg;
    logic [1:0]  MemtoReg, Branch;
    logic [31:0] result, register_data;
    logic [4:0]  rdist, pc1, pc2;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid, uart_rx_ready, busy, wb_valid, wb_RegWrite, wb_AorF;
    logic [4:0]  wb_rdist, br_target;
    logic [31:0] wb_data;
    logic [1:0]  br_Branch;

    int checks = 0;
    int errors = 0;

    memory_access #(.DATA_MEM_WIDTH(10), .INST_MEM_WIDTH(5)) dut (
        .CLK(CLK), .reset(reset), .distinct(distinct), .valid(valid), .AorF(AorF),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Branch(Branch), .MemWrite(MemWrite),
        .MemRead(MemRead), .UARTtoReg(UARTtoReg), .result(result),
        .register_data(register_data), .rdist(rdist), .pc1(pc1), .pc2(pc2),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(uart_rx_ready), .busy(busy), .wb_valid(wb_valid),
        .wb_RegWrite(wb_RegWrite), .wb_AorF(wb_AorF), .wb_rdist(wb_rdist),
        .wb_data(wb_data), .br_Branch(br_Branch), .br_target(br_target)
    );

    always #5 CLK = ~CLK;

    task automatic set_fields(input logic [1:0] mtr, input logic mw, input logic mr,
                              input logic u, input logic rw, input logic [31:0] res,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input logic [1:0] br, input logic [4:0] p1, input logic [4:0] p2);
        MemtoReg = mtr; MemWrite = mw; MemRead = mr; UARTtoReg = u; RegWrite = rw;
        result = res; register_data = wdata; rdist = rd; Branch = br; pc1 = p1; pc2 = p2;
        AorF = 1'b0;
    endtask

    // Presents one bundle for a single cycle; returns on the falling edge after the accept edge.
    task automatic issue(input logic [1:0] mtr, input logic mw, input logic mr,
                         input logic u, input logic rw, input logic [31:0] res,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [1:0] br, input logic [4:0] p1, input logic [4:0] p2);
        @(negedge CLK);
        set_fields(mtr, mw, mr, u, rw, res, wdata, rd, br, p1, p2);
        valid = 1'b1; distinct = 1'b1;
        @(negedge CLK);
        valid = 1'b0; distinct = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        valid = 0; distinct = 0; uart_rx_valid = 0; uart_rx_data = 8'h00;
        set_fields(2'b00, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 2'b00, 5'd0, 5'd0);
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b exp 0", wb_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
            checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b exp 0", uart_rx_ready); end
            checks++; if (br_Branch !== 2'b11) begin errors++; $display("FAIL reset_br_Branch: got %b exp 11", br_Branch); end
        end
        checks++; if (wb_data !== 32'd0 || wb_rdist !== 5'd0 || wb_RegWrite !== 1'b0 || br_target !== 5'd0)
            begin errors++; $display("FAIL reset_regs: data %h rdist %0d rw %b tgt %0d exp all 0", wb_data, wb_rdist, wb_RegWrite, br_target); end
    endtask

    task automatic test_alu;
        issue(2'b00, 0, 0, 0, 1, 32'h1234, 32'd0, 5'd7, 2'b11, 5'd0, 5'd0);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b exp 1", wb_valid); end
        checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL alu_data: got %h exp 00001234", wb_data); end
        checks++; if (wb_rdist !== 5'd7 || wb_RegWrite !== 1'b1) begin errors++; $display("FAIL alu_dest: got rd %0d rw %b exp 7 1", wb_rdist, wb_RegWrite); end
        @(negedge CLK);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_pulse: got %b exp 0", wb_valid); end
        checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL alu_hold: got %h exp 00001234", wb_data); end
    endtask

    task automatic test_load_store;
        issue(2'b00, 1, 0, 0, 0, 32'h40, 32'hDEADBEEF, 5'd0, 2'b11, 5'd0, 5'd0);
        checks++; if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0) begin errors++; $display("FAIL store_wb: got v %b rw %b exp 1 0", wb_valid, wb_RegWrite); end
        issue(2'b01, 0, 1, 0, 1, 32'h43, 32'd0, 5'd3, 2'b11, 5'd0, 5'd0);
        checks++; if (busy !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL load_wait: got busy %b v %b exp 1 0", busy, wb_valid); end
        checks++; if (wb_rdist !== 5'd0) begin errors++; $display("FAIL load_early_rdist: got %0d exp 0", wb_rdist); end
        @(negedge CLK);
        checks++; if (wb_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL load_done: got v %b busy %b exp 1 0", wb_valid, busy); end
        checks++; if (wb_data !== 32'hDEADBEEF || wb_rdist !== 5'd3) begin errors++; $display("FAIL load_data: got %h rd %0d exp deadbeef 3", wb_data, wb_rdist); end
        // 0x1043 has address bits above the array; word index wraps to 16, same as 0x40.
        issue(2'b01, 0, 1, 0, 1, 32'h1043, 32'd0, 5'd5, 2'b11, 5'd0, 5'd0);
        @(negedge CLK);
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_wrap: got v %b %h exp 1 deadbeef", wb_valid, wb_data); end
    endtask

    task automatic test_back_to_back;
        // Store and load both set: the store wins and completes with latency 1.
        @(negedge CLK);
        set_fields(2'b00, 1, 1, 0, 0, 32'hC0, 32'h11112222, 5'd0, 2'b11, 5'd0, 5'd0);
        valid = 1'b1; distinct = 1'b1;
        @(negedge CLK);
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hC0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_store: got v %b %h busy %b exp 1 000000c0 0", wb_valid, wb_data, busy); end
        set_fields(2'b01, 0, 1, 0, 1, 32'hC0, 32'd0, 5'd12, 2'b11, 5'd0, 5'd0);
        @(negedge CLK);
        valid = 1'b0; distinct = 1'b0;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_load_wait: got v %b busy %b exp 0 1", wb_valid, busy); end
        @(negedge CLK);
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h11112222 || wb_rdist !== 5'd12) begin errors++; $display("FAIL b2b_load: got v %b %h rd %0d exp 1 11112222 12", wb_valid, wb_data, wb_rdist); end
    endtask

    task automatic test_uart;
        // MemtoReg=10 must be overridden by the UART byte.
        issue(2'b10, 0, 0, 1, 1, 32'hFFFF, 32'd0, 5'd8, 2'b11, 5'd17, 5'd0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (busy !== 1'b1 || uart_rx_ready !== 1'b0 || wb_valid !== 1'b0)
                begin errors++; $display("FAIL uart_wait: cyc %0d busy %b rdy %b v %b exp 1 0 0", i, busy, uart_rx_ready, wb_valid); end
            @(negedge CLK);
        end
        uart_rx_valid = 1'b1; uart_rx_data = 8'hA5;
        #1;
        checks++; if (uart_rx_ready !== 1'b1) begin errors++; $display("FAIL uart_ready: got %b exp 1", uart_rx_ready); end
        @(negedge CLK);
        uart_rx_valid = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h000000A5 || wb_rdist !== 5'd8) begin errors++; $display("FAIL uart_data: got v %b %h rd %0d exp 1 000000a5 8", wb_valid, wb_data, wb_rdist); end
        checks++; if (uart_rx_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL uart_ready_pulse: got rdy %b busy %b exp 0 0", uart_rx_ready, busy); end
        // Byte already present at accept: not consumed until UART_WAIT, latency 2.
        @(negedge CLK);
        set_fields(2'b00, 0, 0, 1, 1, 32'd0, 32'd0, 5'd9, 2'b11, 5'd0, 5'd0);
        valid = 1'b1; distinct = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'h3C;
        #1;
        checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL uart_stale: got %b exp 0", uart_rx_ready); end
        @(negedge CLK);
        valid = 1'b0; distinct = 1'b0;
        checks++; if (uart_rx_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL uart_stale_take: got rdy %b v %b exp 1 0", uart_rx_ready, wb_valid); end
        @(negedge CLK);
        uart_rx_valid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0000003C) begin errors++; $display("FAIL uart_stale_data: got v %b %h exp 1 0000003c", wb_valid, wb_data); end
    endtask

    task automatic test_link;
        issue(2'b10, 0, 0, 0, 1, 32'h999, 32'd0, 5'd1, 2'b01, 5'd5, 5'd9);
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd5) begin errors++; $display("FAIL link_data: got v %b %h exp 1 00000005", wb_valid, wb_data); end
        checks++; if (br_Branch !== 2'b01 || br_target !== 5'd9) begin errors++; $display("FAIL link_branch: got %b %0d exp 01 9", br_Branch, br_target); end
        @(negedge CLK);
        checks++; if (br_Branch !== 2'b01 || br_target !== 5'd9) begin errors++; $display("FAIL link_hold: got %b %0d exp 01 9", br_Branch, br_target); end
    endtask

    task automatic test_drop_and_distinct;
        issue(2'b01, 0, 1, 0, 1, 32'h40, 32'd0, 5'd4, 2'b11, 5'd0, 5'd0);
        set_fields(2'b00, 0, 0, 0, 1, 32'h77, 32'd0, 5'd6, 2'b00, 5'd0, 5'd0);
        valid = 1'b1; distinct = 1'b1;
        @(negedge CLK);
        valid = 1'b0; distinct = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_rdist !== 5'd4) begin errors++; $display("FAIL drop_load: got v %b %h rd %0d exp 1 deadbeef 4", wb_valid, wb_data, wb_rdist); end
        @(negedge CLK);
        checks++; if (wb_valid !== 1'b0 || wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL drop_busy: got v %b %h exp 0 deadbeef", wb_valid, wb_data); end
        set_fields(2'b00, 0, 0, 0, 1, 32'h55, 32'd0, 5'd2, 2'b00, 5'd0, 5'd0);
        valid = 1'b1; distinct = 1'b0;
        @(negedge CLK);
        valid = 1'b0;
        checks++; if (wb_valid !== 1'b0 || wb_data !== 32'hDEADBEEF || br_Branch !== 2'b11) begin errors++; $display("FAIL bubble: got v %b %h br %b exp 0 deadbeef 11", wb_valid, wb_data, br_Branch); end
    endtask

    task automatic test_reset_mid;
        issue(2'b00, 0, 0, 1, 1, 32'd0, 32'd0, 5'd9, 2'b00, 5'd0, 5'd3);
        reset = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'h77;
        #1;
        checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rst_uart_ready: got %b exp 0", uart_rx_ready); end
        @(negedge CLK);
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || uart_rx_ready !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL rst_uart_idle: got busy %b rdy %b v %b exp 0 0 0", busy, uart_rx_ready, wb_valid); end
        checks++; if (wb_data !== 32'd0 || br_Branch !== 2'b11) begin errors++; $display("FAIL rst_uart_regs: got %h %b exp 0 11", wb_data, br_Branch); end
        @(negedge CLK);
        uart_rx_valid = 1'b0;
        checks++; if (wb_valid !== 1'b0 || uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rst_uart_after: got v %b rdy %b exp 0 0", wb_valid, uart_rx_ready); end
        // Load abandoned by reset.
        issue(2'b01, 0, 1, 0, 1, 32'h40, 32'd0, 5'd4, 2'b11, 5'd0, 5'd0);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_load: got v %b busy %b exp 0 0", wb_valid, busy); end
        // Store presented during reset must not write.
        @(negedge CLK);
        set_fields(2'b00, 1, 0, 0, 0, 32'h40, 32'hBAD0BAD0, 5'd0, 2'b11, 5'd0, 5'd0);
        valid = 1'b1; distinct = 1'b1; reset = 1'b1;
        @(negedge CLK);
        valid = 1'b0; distinct = 1'b0; reset = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_store_wb: got %b exp 0", wb_valid); end
        issue(2'b01, 0, 1, 0, 1, 32'h40, 32'd0, 5'd4, 2'b11, 5'd0, 5'd0);
        @(negedge CLK);
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_store_mem: got v %b %h exp 1 deadbeef", wb_valid, wb_data); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_load_store;
        test_back_to_back;
        test_uart;
        test_link;
        test_drop_and_distinct;
        test_reset_mid;
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
